fft_loader: RTL

- Reads one FFT frame of 2^BW_FFTP consecutive samples for one channel (L or R) from the SRAM ring buffer that the I2S capture stage fills at 18'h0E000–18'h0FFFF (L) and 18'h1E000–18'h1FFFF (R).
- Applies a window coefficient to each sample and streams the windowed samples, oldest first, to the FFT input.
- Sits between the SRAM arbiter (read port) and the FFT core.
- Uses the capture stage's 13-bit LastWriteAddr to locate the newest complete sample.

---
 rtl/fft_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/fft_loader.sv
// Streams one windowed FFT frame (oldest sample first) out of the I2S SRAM ring buffer.
// Reads are issued through the arbiter; a shift register tags each outstanding read with its index.
module fft_loader #(
    parameter int BW_FFTP = 10,
    parameter int RAM_LAT = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               i_Start,
    input  logic               i_Channel,
    input  logic [12:0]        i_LastWriteAddr,
    output logic               o_RdReq,
    input  logic               i_RdGrant,
    output logic [17:0]        o_RdAddress,
    input  logic [15:0]        i_RdData,
    output logic [BW_FFTP-1:0] o_WinAddr,
    input  logic [15:0]        i_WinCoef,
    output logic [15:0]        o_OutData,
    output logic               o_OutValid,
    output logic [BW_FFTP-1:0] o_OutIndex,
    output logic               o_Busy,
    output logic               o_Done
);

    // N mod 8192: the oldest sample sits N-1 behind S = LastWriteAddr-1, i.e. LastWriteAddr-N.
    localparam logic [12:0]        NMOD  = 13'((1 << BW_FFTP) % 8192);
    localparam logic [BW_FFTP-1:0] KLAST = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                          r_state, w_next;
    logic                            r_chan;
    logic [12:0]                     r_base;
    logic [BW_FFTP-1:0]              r_k;
    logic [RAM_LAT-1:0]              r_vld;
    logic [RAM_LAT-1:0][BW_FFTP-1:0] r_idx;

    logic                            w_issue;
    logic [12:0]                     w_ofs;
    logic signed [32:0]              w_prod;

    assign w_issue = (r_state == ISSUE) && i_RdGrant;
    assign w_ofs   = r_base + 13'(r_k);
    assign w_prod  = $signed(i_RdData) * $signed({1'b0, i_WinCoef});

    always_comb begin
        w_next      = r_state;
        o_RdReq     = 1'b0;
        o_RdAddress = '0;
        o_Done      = 1'b0;
        o_Busy      = (r_state != IDLE);
        o_WinAddr   = r_k;
        case (r_state)
            IDLE:  if (i_Start) w_next = ISSUE;
            ISSUE: begin
                o_RdReq     = 1'b1;
                o_RdAddress = {1'b0, r_chan, 3'b111, w_ofs};
                if (w_issue && r_k == KLAST) w_next = DRAIN;
            end
            // Outputs arrive strictly in order, so index N-1 marks the end of the frame.
            DRAIN: if (o_OutValid && o_OutIndex == KLAST) w_next = FIN;
            FIN: begin
                o_Done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_chan     <= 1'b0;
            r_base     <= '0;
            r_k        <= '0;
            r_vld      <= '0;
            r_idx      <= '0;
            o_OutData  <= '0;
            o_OutValid <= 1'b0;
            o_OutIndex <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_Start) begin
                r_chan <= i_Channel;
                r_base <= i_LastWriteAddr - NMOD;
                r_k    <= '0;
            end else if (w_issue) begin
                r_k <= r_k + BW_FFTP'(1);
            end

            r_vld[0] <= w_issue;
            r_idx[0] <= r_k;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end

            // Q0.16 window: keep bits [31:16] of the product (floor toward -inf).
            o_OutValid <= r_vld[RAM_LAT-1];
            if (r_vld[RAM_LAT-1]) begin
                o_OutData  <= 16'(w_prod >>> 16);
                o_OutIndex <= r_idx[RAM_LAT-1];
            end
        end
    end

endmodule
